// File: rtl/testbasic20_types.sv
`default_nettype none
// ============================================================================
// Package     : testbasic20_types
// Description : Shared types for the TestBasic20 CompoundType link. Provides
//               the transfer mode, the colour state, the CompoundType word,
//               the receiver section encoding and the colour sequencing
//               helper.
// Revision    : 1.0 - initial release
// ============================================================================
package testbasic20_types;

  typedef enum logic {
    read  = 1'b0,
    write = 1'b1
  } mode_t;

  typedef enum logic [1:0] {
    green = 2'd0,
    blue  = 2'd1,
    red   = 2'd2
  } color_t;

  typedef struct packed {
    mode_t              mode;
    logic signed [31:0] x;
    logic               y;
  } CompoundType;

  typedef enum logic {
    section_recv = 1'b0,
    section_proc = 1'b1
  } CompoundReceiver_SECTIONS;

  // Colour sequence green -> blue -> red -> green. The unused encoding
  // recovers to green.
  function automatic color_t next_color(input color_t c);
    color_t n;
    case (c)
      green:   n = blue;
      blue:    n = red;
      red:     n = green;
      default: n = green;
    endcase
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/compound_receiver.sv
`default_nettype none
// ============================================================================
// Module      : compound_receiver
// Description : Consumer end of the blocking CompoundType port. Accepts one
//               word per handshake, holds it for PROC_CYCLES cycles, then
//               commits it: write words accumulate x, read words report the
//               accumulator, and y advances the colour state.
// Ports       : clk         - system clock, rising edge
//               rst         - synchronous active-high reset
//               b_in        - CompoundType word from the producer
//               b_in_sync   - producer has valid data on b_in
//               b_in_notify - receiver ready (transfer on sync && notify)
//               m_out       - last processing result, no handshake
//               color_out   - current colour state
//               xfer_cnt    - accepted transfers, saturating
// Revision    : 1.0 - initial release
// ============================================================================
module compound_receiver
  import testbasic20_types::*;
#(
  parameter int PROC_CYCLES = 1,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  CompoundType       b_in,
  input  logic              b_in_sync,
  output logic              b_in_notify,
  output CompoundType       m_out,
  output color_t            color_out,
  output logic [CNT_W-1:0]  xfer_cnt
);

  generate
    if (PROC_CYCLES < 1 || PROC_CYCLES > 15) begin : g_bad_proc_cycles
      $error("compound_receiver: PROC_CYCLES must be in 1..15");
    end
  endgenerate

  localparam logic [3:0]       PROC_LOAD = 4'(PROC_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  CompoundReceiver_SECTIONS state;
  CompoundReceiver_SECTIONS next_state;

  CompoundType  latched;
  logic [3:0]   proc_cnt;
  logic [31:0]  acc;
  logic [31:0]  acc_sum;
  logic         handshake;
  logic         commit;

  assign handshake = b_in_sync && b_in_notify;
  // The last cycle of section_proc is the one in which the count has run out.
  assign commit    = (state == section_proc) && (proc_cnt == 4'd0);
  assign acc_sum   = acc + latched.x;

  always_comb begin
    next_state = state;
    case (state)
      section_recv: if (handshake) next_state = section_proc;
      section_proc: if (commit)    next_state = section_recv;
      default:                     next_state = section_recv;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= section_recv;
      b_in_notify <= 1'b1;
      m_out       <= '{mode: read, x: 32'sd0, y: 1'b0};
      color_out   <= green;
      acc         <= 32'd0;
      xfer_cnt    <= '0;
      proc_cnt    <= 4'd0;
      latched     <= '{mode: read, x: 32'sd0, y: 1'b0};
    end else begin
      state <= next_state;

      if (state == section_recv) begin
        if (handshake) begin
          latched     <= b_in;
          proc_cnt    <= PROC_LOAD;
          b_in_notify <= 1'b0;
        end
      end else if (!commit) begin
        proc_cnt <= proc_cnt - 4'd1;
      end else begin
        b_in_notify <= 1'b1;

        if (latched.mode == write) begin
          acc   <= acc_sum;
          m_out <= '{mode: write, x: acc_sum, y: latched.y};
        end else begin
          m_out <= '{mode: read, x: acc, y: latched.y};
        end

        if (latched.y) begin
          color_out <= next_color(color_out);
        end

        if (xfer_cnt != CNT_MAX) begin
          xfer_cnt <= xfer_cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_compound_receiver.sv
`default_nettype none
// ============================================================================
// Module      : tb_compound_receiver
// Description : Directed self-checking bench for compound_receiver. Two
//               instances share clk/rst: dut_a (PROC_CYCLES=1, CNT_W=16) and
//               dut_b (PROC_CYCLES=4, CNT_W=2, so saturation is reachable
//               in a few words).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_compound_receiver;
  import testbasic20_types::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  CompoundType b_a, m_a, b_b, m_b;
  logic        sync_a, notify_a, sync_b, notify_b;
  color_t      col_a, col_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  compound_receiver #(.PROC_CYCLES(1), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .b_in(b_a), .b_in_sync(sync_a),
    .b_in_notify(notify_a), .m_out(m_a), .color_out(col_a), .xfer_cnt(cnt_a)
  );

  compound_receiver #(.PROC_CYCLES(4), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .b_in(b_b), .b_in_sync(sync_b),
    .b_in_notify(notify_b), .m_out(m_b), .color_out(col_b), .xfer_cnt(cnt_b)
  );

  function automatic CompoundType cw(input mode_t m, input logic [31:0] x, input logic y);
    CompoundType w;
    w.mode = m;
    w.x    = x;
    w.y    = y;
    return w;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one word to dut_a and return just after its commit edge.
  task automatic xfer_a(input CompoundType w);
    int t = 0;
    b_a = w;
    sync_a = 1'b1;
    while (!notify_a && t < 20) begin
      tick();
      t++;
    end
    vectors++;
    if (notify_a !== 1'b1) begin
      errors++;
      $display("FAIL xfer_a_ready notify=%b expected=1", notify_a);
    end
    tick();
    sync_a = 1'b0;
    tick();
  endtask

  // Offer one word to dut_b and return just after its commit edge.
  task automatic xfer_b(input CompoundType w);
    int t = 0;
    b_b = w;
    sync_b = 1'b1;
    while (!notify_b && t < 20) begin
      tick();
      t++;
    end
    vectors++;
    if (notify_b !== 1'b1) begin
      errors++;
      $display("FAIL xfer_b_ready notify=%b expected=1", notify_b);
    end
    tick();
    sync_b = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    sync_a = 1'b0;
    sync_b = 1'b0;
    b_a = '0;
    b_b = '0;
    tick();
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if ({notify_a, m_a, col_a, cnt_a} !== {1'b1, cw(read, 32'd0, 1'b0), green, 16'd0}) begin
        errors++;
        $display("FAIL reset_idle_a cyc=%0d got=%h expected=%h", i,
                 {notify_a, m_a, col_a, cnt_a}, {1'b1, cw(read, 32'd0, 1'b0), green, 16'd0});
      end
      vectors++;
      if ({notify_b, m_b, col_b, cnt_b} !== {1'b1, cw(read, 32'd0, 1'b0), green, 2'd0}) begin
        errors++;
        $display("FAIL reset_idle_b cyc=%0d got=%h expected=%h", i,
                 {notify_b, m_b, col_b, cnt_b}, {1'b1, cw(read, 32'd0, 1'b0), green, 2'd0});
      end
      tick();
    end
  endtask

  task automatic test_basic();
    CompoundType w[3];
    CompoundType e[3];
    color_t      ec[3];
    CompoundType prev;
    w[0] = cw(write, 32'd5, 1'b0);          e[0] = cw(write, 32'd5, 1'b0); ec[0] = green;
    w[1] = cw(write, 32'hFFFF_FFFD, 1'b1);  e[1] = cw(write, 32'd2, 1'b1); ec[1] = blue;
    w[2] = cw(read, 32'd0, 1'b0);           e[2] = cw(read, 32'd2, 1'b0);  ec[2] = blue;
    prev = cw(read, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      b_a = w[i];
      sync_a = 1'b1;
      tick();
      sync_a = 1'b0;
      b_a = cw(write, 32'hDEAD_BEEF, 1'b1);
      vectors++;
      if ({notify_a, m_a} !== {1'b0, prev}) begin
        errors++;
        $display("FAIL basic_busy word=%0d got=%h expected=%h", i, {notify_a, m_a}, {1'b0, prev});
      end
      tick();
      vectors++;
      if ({notify_a, m_a, col_a, cnt_a} !== {1'b1, e[i], ec[i], 16'(i + 1)}) begin
        errors++;
        $display("FAIL basic_commit word=%0d got=%h expected=%h", i,
                 {notify_a, m_a, col_a, cnt_a}, {1'b1, e[i], ec[i], 16'(i + 1)});
      end
      prev = e[i];
    end
  endtask

  task automatic test_wrap();
    // acc is 2 here; bring it to 0x7FFFFFFF and then step over the top.
    xfer_a(cw(write, 32'h7FFF_FFFD, 1'b0));
    vectors++;
    if (m_a !== cw(write, 32'h7FFF_FFFF, 1'b0)) begin
      errors++;
      $display("FAIL wrap_setup got=%h expected=%h", m_a, cw(write, 32'h7FFF_FFFF, 1'b0));
    end
    xfer_a(cw(write, 32'd1, 1'b0));
    vectors++;
    if ({m_a, col_a, cnt_a} !== {cw(write, 32'h8000_0000, 1'b0), blue, 16'd5}) begin
      errors++;
      $display("FAIL wrap got=%h expected=%h", {m_a, col_a, cnt_a},
               {cw(write, 32'h8000_0000, 1'b0), blue, 16'd5});
    end
  endtask

  task automatic test_sync_held();
    b_b = cw(write, 32'd10, 1'b0);
    sync_b = 1'b1;
    tick();
    for (int i = 1; i <= 3; i++) begin
      b_b = cw(write, 32'(100 + i), 1'b1);
      tick();
      vectors++;
      if ({notify_b, m_b, cnt_b} !== {1'b0, cw(read, 32'd0, 1'b0), 2'd0}) begin
        errors++;
        $display("FAIL held_busy edge=%0d got=%h expected=%h", i,
                 {notify_b, m_b, cnt_b}, {1'b0, cw(read, 32'd0, 1'b0), 2'd0});
      end
    end
    b_b = cw(write, 32'd20, 1'b1);
    tick();
    vectors++;
    if ({notify_b, m_b, col_b, cnt_b} !== {1'b1, cw(write, 32'd10, 1'b0), green, 2'd1}) begin
      errors++;
      $display("FAIL held_commit got=%h expected=%h", {notify_b, m_b, col_b, cnt_b},
               {1'b1, cw(write, 32'd10, 1'b0), green, 2'd1});
    end
    // sync is still high: the next edge is the second handshake.
    tick();
    sync_b = 1'b0;
    vectors++;
    if (notify_b !== 1'b0) begin
      errors++;
      $display("FAIL held_second_hs notify=%b expected=0", notify_b);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (m_b !== cw(write, 32'd10, 1'b0)) begin
        errors++;
        $display("FAIL held_second_busy i=%0d got=%h expected=%h", i, m_b, cw(write, 32'd10, 1'b0));
      end
    end
    tick();
    vectors++;
    if ({notify_b, m_b, col_b, cnt_b} !== {1'b1, cw(write, 32'd30, 1'b1), blue, 2'd2}) begin
      errors++;
      $display("FAIL held_second_commit got=%h expected=%h", {notify_b, m_b, col_b, cnt_b},
               {1'b1, cw(write, 32'd30, 1'b1), blue, 2'd2});
    end
  endtask

  task automatic test_color_sat();
    color_t ec[3];
    ec[0] = blue;
    ec[1] = red;
    ec[2] = green;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      xfer_b(cw(read, 32'd0, 1'b1));
      vectors++;
      if ({col_b, cnt_b} !== {ec[i], 2'(i + 1)}) begin
        errors++;
        $display("FAIL color_step i=%0d got=%h expected=%h", i, {col_b, cnt_b}, {ec[i], 2'(i + 1)});
      end
    end
    // The 2-bit counter is at its ceiling of 3.
    xfer_b(cw(write, 32'd9, 1'b0));
    vectors++;
    if ({m_b, col_b, cnt_b} !== {cw(write, 32'd9, 1'b0), green, 2'd3}) begin
      errors++;
      $display("FAIL cnt_saturate got=%h expected=%h", {m_b, col_b, cnt_b},
               {cw(write, 32'd9, 1'b0), green, 2'd3});
    end
  endtask

  task automatic test_reset_mid();
    b_a = cw(write, 32'd7, 1'b1);
    b_b = cw(write, 32'd7, 1'b1);
    sync_a = 1'b1;
    sync_b = 1'b1;
    tick();
    sync_a = 1'b0;
    sync_b = 1'b0;
    vectors++;
    if ({notify_a, notify_b} !== 2'b00) begin
      errors++;
      $display("FAIL mid_latched notify=%b expected=00", {notify_a, notify_b});
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({notify_a, m_a, col_a, cnt_a} !== {1'b1, cw(read, 32'd0, 1'b0), green, 16'd0}) begin
      errors++;
      $display("FAIL mid_reset_a got=%h expected=%h", {notify_a, m_a, col_a, cnt_a},
               {1'b1, cw(read, 32'd0, 1'b0), green, 16'd0});
    end
    vectors++;
    if ({notify_b, m_b, col_b, cnt_b} !== {1'b1, cw(read, 32'd0, 1'b0), green, 2'd0}) begin
      errors++;
      $display("FAIL mid_reset_b got=%h expected=%h", {notify_b, m_b, col_b, cnt_b},
               {1'b1, cw(read, 32'd0, 1'b0), green, 2'd0});
    end
    xfer_a(cw(read, 32'd0, 1'b0));
    vectors++;
    if ({m_a, col_a, cnt_a} !== {cw(read, 32'd0, 1'b0), green, 16'd1}) begin
      errors++;
      $display("FAIL mid_acc_a got=%h expected=%h", {m_a, col_a, cnt_a},
               {cw(read, 32'd0, 1'b0), green, 16'd1});
    end
    xfer_b(cw(read, 32'd0, 1'b0));
    vectors++;
    if ({m_b, col_b, cnt_b} !== {cw(read, 32'd0, 1'b0), green, 2'd1}) begin
      errors++;
      $display("FAIL mid_acc_b got=%h expected=%h", {m_b, col_b, cnt_b},
               {cw(read, 32'd0, 1'b0), green, 2'd1});
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_sync_held();
    test_color_sat();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
